// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 5-stage pipeline: opcode/ALU-op encodings,
// special registers, instruction field helpers and the multdiv sequencer states.
package proc_isa_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned REG_W   = 5;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 5'd0;
  localparam logic [OPC_W-1:0] OPC_BNE   = 5'd2;
  localparam logic [OPC_W-1:0] OPC_JAL   = 5'd3;
  localparam logic [OPC_W-1:0] OPC_JR    = 5'd4;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_BLT   = 5'd6;
  localparam logic [OPC_W-1:0] OPC_SW    = 5'd7;
  localparam logic [OPC_W-1:0] OPC_LW    = 5'd8;
  localparam logic [OPC_W-1:0] OPC_SETX  = 5'd21;
  localparam logic [OPC_W-1:0] OPC_BEX   = 5'd22;

  localparam logic [ALUOP_W-1:0] ALUOP_MUL = 5'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV = 5'd7;

  localparam logic [REG_W-1:0] REG_RSTATUS = 5'd30;
  localparam logic [REG_W-1:0] REG_RA      = 5'd31;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[31:27];
  endfunction

  function automatic logic [ALUOP_W-1:0] instr_aluop(input logic [INSTR_W-1:0] instr);
    return instr[6:2];
  endfunction

  function automatic logic [REG_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[26:22];
  endfunction

endpackage

// File: rtl/md_instr_decode.sv
// Combinational mul/div recogniser for a 32-bit instruction word; shared
// between the multdiv sequencer and the hazard logic.
module md_instr_decode
  import proc_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               is_mul,
  output logic               is_div
);

  logic is_rtype;
  logic unused_bits;

  assign is_rtype    = (instr_opcode(instr) == OPC_RTYPE);
  assign is_mul      = is_rtype && (instr_aluop(instr) == ALUOP_MUL);
  assign is_div      = is_rtype && (instr_aluop(instr) == ALUOP_DIV);
  assign unused_bits = ^{instr[26:7], instr[1:0]};

endmodule

// File: rtl/multdiv_stall_controller.sv
// X-stage sequencer for the multi-cycle multdiv unit: freezes the front of the
// pipeline, launches the operation and hands the result/exception to XM.
module multdiv_stall_controller
  import proc_isa_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 34,
  parameter int unsigned EXC_MUL    = 4,
  parameter int unsigned EXC_DIV    = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [INSTR_W-1:0]  dx_instr,
  input  logic                dx_flush,
  input  logic [31:0]         alu_a_in,
  input  logic [31:0]         alu_b_in,
  input  logic                md_result_rdy,
  input  logic [31:0]         md_result,
  input  logic                md_exception,
  output logic                md_ctrl_mult,
  output logic                md_ctrl_div,
  output logic [31:0]         md_operand_a,
  output logic [31:0]         md_operand_b,
  output logic                stall,
  output logic                result_valid,
  output logic [31:0]         result_data,
  output logic                exc_valid,
  output logic [31:0]         exc_code
);

  localparam int unsigned CNT_W       = $clog2(MAX_CYCLES + 1);
  localparam logic [31:0] MUL_CODE    = 32'(EXC_MUL);
  localparam logic [31:0] DIV_CODE    = 32'(EXC_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             op_is_div;
  logic             is_mul;
  logic             is_div;
  logic             md_detect;
  logic [31:0]      op_code;

  md_instr_decode u_decode (
    .instr  (dx_instr),
    .is_mul (is_mul),
    .is_div (is_div)
  );

  assign md_detect = (is_mul || is_div) && !dx_flush;
  assign op_code   = op_is_div ? DIV_CODE : MUL_CODE;

  // Start pulses and stall must act in the detect cycle itself, so they are combinational.
  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    stall        = 1'b0;
    if (state == IDLE) begin
      md_ctrl_mult = is_mul && !dx_flush;
      md_ctrl_div  = is_div && !dx_flush;
      stall        = md_detect;
    end else if (state == BUSY) begin
      stall = 1'b1;
    end
  end

  // Sequencer state plus registered operands and XM-side result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cycle_cnt    <= '0;
      op_is_div    <= 1'b0;
      md_operand_a <= '0;
      md_operand_b <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_detect) begin
            md_operand_a <= alu_a_in;
            md_operand_b <= alu_b_in;
            op_is_div    <= is_div;
            cycle_cnt    <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
          if (md_result_rdy) begin
            result_valid <= 1'b1;
            result_data  <= md_result;
            exc_valid    <= md_exception;
            exc_code     <= md_exception ? op_code : 32'd0;
            state        <= DONE;
          end else if (cycle_cnt == CNT_LAST) begin
            // Timeout: abort with the operation's exception code and a zero result.
            result_valid <= 1'b1;
            result_data  <= '0;
            exc_valid    <= 1'b1;
            exc_code     <= op_code;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          exc_valid    <= 1'b0;
          exc_code     <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
